// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: opcodes, FSM states,
// division step count and the sign-aware 33x33 multiply helper.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = 6;

    // Operands are extended to 33 bits (sign for MULT, zero for MULTU) so one
    // signed multiplier covers both; only the low 64 product bits are kept.
    function automatic logic [63:0] mul64(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic               sgn;
        logic signed [32:0] ea;
        logic signed [32:0] eb;
        logic signed [63:0] p;
        sgn = (op == OP_MULT);
        ea  = {sgn & a[31], a};
        eb  = {sgn & b[31], b};
        p   = 64'(ea) * 64'(eb);
        return p;
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module muldiv_div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] dvs_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shifted;
    logic [32:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[31]};
        diff    = shifted - {1'b0, dvs_i};
        // A full 33-bit compare keeps divisor 0 correct: every bit then
        // subtracts zero, giving an all-ones quotient and remainder = dividend.
        if (shifted >= {1'b0, dvs_i}) begin
            rem_o = diff[31:0];
            quo_o = {quo_i[30:0], 1'b1};
        end else begin
            rem_o = shifted[31:0];
            quo_o = {quo_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Optional macro MULDIV_EARLY_DIV0_EN: divide-by-zero finishes right after setup and pulses div0.
module muldiv_hilo_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div0,
    output logic [1:0]  dbg_state
);

    localparam logic [CNT_W-1:0] MUL_END = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_END = CNT_W'(DIV_STEPS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic [31:0]        a_q, b_q, rem_q, quo_q, dvs_q, hi_q, lo_q;
    logic [31:0]        abs_a, abs_b, step_rem, step_quo, fix_rem, fix_quo;
    logic [31:0]        res_hi, res_lo;
    logic [63:0]        product;
    logic               accept, res_we, a_neg, q_neg;

    // Accept handshake: start is taken only in IDLE/DONE and loses to flush.
    assign accept = start && !flush && (state_q == ST_IDLE || state_q == ST_DONE);
    assign busy   = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done   = (state_q == ST_DONE);
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign dbg_state = state_q;

    // With MUL_LAT==1 the product is written on the accept edge from the live inputs.
    assign product = mul64(accept ? op : op_q, accept ? a : a_q, accept ? b : b_q);

    assign a_neg = (op_q == OP_DIV) && a_q[31];
    assign q_neg = (op_q == OP_DIV) && (a_q[31] ^ b_q[31]);
    assign abs_a = a_neg ? (~a_q + 32'd1) : a_q;
    assign abs_b = ((op_q == OP_DIV) && b_q[31]) ? (~b_q + 32'd1) : b_q;
    assign fix_quo = q_neg ? (~step_quo + 32'd1) : step_quo;
    assign fix_rem = a_neg ? (~step_rem + 32'd1) : step_rem;

    muldiv_div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

`ifdef MULDIV_EARLY_DIV0_EN
    logic div0_d, div0_q;
    assign div0 = div0_q;
`else
    assign div0 = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        res_we  = 1'b0;
        res_hi  = product[63:32];
        res_lo  = product[31:0];
`ifdef MULDIV_EARLY_DIV0_EN
        div0_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (op[1]) begin
                        state_d = ST_DIV;
                    end else if (MUL_LAT == 1) begin
                        state_d = ST_DONE;
                        res_we  = 1'b1;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == MUL_END) begin
                    state_d = ST_DONE;
                    res_we  = 1'b1;
                end
            end
            ST_DIV: begin
                // cnt 0 is setup, 1..DIV_STEPS are steps; the sign fix rides the final edge.
                if (flush) begin
                    state_d = ST_IDLE;
`ifdef MULDIV_EARLY_DIV0_EN
                end else if (cnt_q == '0 && b_q == '0) begin
                    state_d = ST_DONE;
                    res_we  = 1'b1;
                    res_hi  = a_q;
                    res_lo  = a_neg ? 32'h0000_0001 : 32'hFFFF_FFFF;
                    div0_d  = 1'b1;
`endif
                end else if (cnt_q == DIV_END) begin
                    state_d = ST_DONE;
                    res_we  = 1'b1;
                    res_hi  = fix_rem;
                    res_lo  = fix_quo;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= op;
                a_q   <= a;
                b_q   <= b;
                cnt_q <= '0;
            end else if (busy) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == ST_DIV) begin
                if (cnt_q == '0) begin
                    rem_q <= '0;
                    quo_q <= abs_a;
                    dvs_q <= abs_b;
                end else begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                end
            end
            // A result write outranks MTHI/MTLO; those only land outside MUL/DIV.
            if (res_we) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (!busy) begin
                if (hi_we) hi_q <= wdata;
                if (lo_we) lo_q <= wdata;
            end
        end
    end

`ifdef MULDIV_EARLY_DIV0_EN
    always_ff @(posedge clk) begin
        if (rst) div0_q <= 1'b0;
        else     div0_q <= div0_d;
    end
`endif

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: stimulus pushes expected {div0,hi,lo,done_cycle}
// into a queue and a negedge monitor pops and compares on every done pulse.
module tb_muldiv_hilo_ctrl;
    import muldiv_pkg::*;

    localparam int W = 81;
`ifdef MULDIV_EARLY_DIV0_EN
    localparam int   DIV0_LAT  = 2;
    localparam logic DIV0_FLAG = 1'b1;
`else
    localparam int   DIV0_LAT  = 34;
    localparam logic DIV0_FLAG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div0;
    logic [31:0] hi, lo;
    logic [1:0]  dbg_state;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [W-1:0] exp_q[$];

    muldiv_hilo_ctrl #(.MUL_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .div0      (div0),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst === 1'b0 && done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: done at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e[15:0]));
                chk("hi", hi, e[79:48]);
                chk("lo", lo, e[47:16]);
                chk("div0", 32'(div0), 32'(e[80]));
            end
        end
    end

    // driver tasks (called at #1 after a posedge)
    task automatic issue_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] ehi, input logic [31:0] elo, input logic ed0,
                            input int lat);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        exp_q.push_back({ed0, ehi, elo, 16'(cyc + lat)});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_busy);
        int n = 0;
        int w = 0;
        while (done !== 1'b1 && w < 100) begin
            if (busy === 1'b1) n++;
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 100) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles, expected one", w);
        end
        chk("busy_cycles", 32'(n), 32'(exp_busy));
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic ed0,
                          input int lat);
        @(posedge clk);
        #1;
        issue_op(o, av, bv, ehi, elo, ed0, lat);
        wait_done(lat - 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int n0;
        rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = OP_MULT; a = '0; b = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_div0", 32'(div0), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;

        // multiply vectors
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 2);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 2);
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 2);
        run_op(OP_MULTU, 32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000, 1'b0, 2);
        run_op(OP_MULT,  32'h8000_0000, 32'd2,        32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 2);

        // divide vectors
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        run_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 34);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34);
        run_op(OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34);
        run_op(OP_DIV,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, 34);
        run_op(OP_DIVU, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, DIV0_FLAG, DIV0_LAT);
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'h0000_0001, DIV0_FLAG, DIV0_LAT);
        run_op(OP_DIV,  32'd9,         32'd0,         32'h0000_0009, 32'hFFFF_FFFF, DIV0_FLAG, DIV0_LAT);

        // flush at cycle 10 of a DIV, then stay idle: no done, hi/lo kept
        @(posedge clk); #1;
        issue_op(OP_DIV, 32'd50, 32'd5, 32'd0, 32'd10, 1'b0, 34);
        void'(exp_q.pop_back());
        n0 = done_cnt;
        repeat (9) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        repeat (30) @(posedge clk);
        #1;
        chk("flush_no_done", 32'(done_cnt), 32'(n0));
        chk("flush_hi", hi, 32'h0000_0009);
        chk("flush_lo", lo, 32'hFFFF_FFFF);

        // flush at cycle 10, start accepted in the very next cycle
        @(posedge clk); #1;
        issue_op(OP_DIVU, 32'd50, 32'd5, 32'd0, 32'd10, 1'b0, 34);
        void'(exp_q.pop_back());
        repeat (9) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        issue_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 2);
        wait_done(1);

        // flush beats start in IDLE
        @(posedge clk); #1;
        n0 = done_cnt;
        start = 1'b1; flush = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("flush_start_no_done", 32'(done_cnt), 32'(n0));

        // MTLO/MTHI in IDLE
        lo_we = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1; lo_we = 1'b0;
        chk("mtlo_idle", lo, 32'h0000_1234);
        hi_we = 1'b1; wdata = 32'h0000_ABCD;
        @(posedge clk); #1; hi_we = 1'b0;
        chk("mthi_idle", hi, 32'h0000_ABCD);

        // MTLO while busy is ignored
        issue_op(OP_DIV, 32'd100, 32'd7, 32'd2, 32'hE, 1'b0, 34);
        lo_we = 1'b1; wdata = 32'h0000_5555;
        @(posedge clk); #1; lo_we = 1'b0;
        chk("mtlo_busy", lo, 32'h0000_1234);
        wait_done(32);

        // MTHI alongside an accepted start lands first, result overwrites later
        @(posedge clk); #1;
        hi_we = 1'b1; wdata = 32'h0000_DEAD;
        issue_op(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 2);
        hi_we = 1'b0;
        chk("mthi_with_start", hi, 32'h0000_DEAD);
        wait_done(1);

        // reset in the middle of a DIV
        @(posedge clk); #1;
        issue_op(OP_DIV, 32'd100, 32'd7, 32'd2, 32'hE, 1'b0, 34);
        void'(exp_q.pop_back());
        n0 = done_cnt;
        repeat (5) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt), 32'(n0));

        // final report
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
